// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Serial UART transmitter. Accepts one byte when idle and sends it as an 8N1
// frame (start bit, 8 data bits LSB first, stop bit) on an idle-high line.
// Every output comes straight from a flop, so the line is glitch-free.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 frame).
//
// Parameters:
//   BAUD_DIV   clock cycles per serial bit (2..65535)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   tx_data    byte to send, sampled only on the accept cycle
//   tx_en      send request, acted on only while tx_status = 1
//   tx_status  1 = idle and ready to accept, 0 = frame in progress
//   uart_tx    serial line, idle high
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, ready; accept on tx_en
// S_START  | start bit (line low) for BAUD_DIV cycles
// S_DATA   | data bit shift_q[0] for BAUD_DIV cycles, 8 bits
// S_PARITY | even parity of the byte for BAUD_DIV cycles (parity build)
// S_STOP   | stop bit (line high) for BAUD_DIV cycles, then ready
//
module uart_tx_serializer #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       uart_tx
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_TC = CNT_W'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             uart_tx_q,  uart_tx_d;
    logic             tx_status_q, tx_status_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q,   parity_d;
`endif

    logic baud_tc;

    assign baud_tc = (baud_cnt_q == BAUD_TC);

    // The line value is computed for the state being entered, so uart_tx
    // changes on the same edge as the state and stays registered.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        uart_tx_d   = uart_tx_q;
        tx_status_d = tx_status_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                uart_tx_d   = 1'b1;
                tx_status_d = 1'b1;
                if (tx_en) begin
                    shift_d     = tx_data;
                    baud_cnt_d  = '0;
                    bit_cnt_d   = 3'd0;
                    state_d     = S_START;
                    uart_tx_d   = 1'b0;
                    tx_status_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d    = ^tx_data;
`endif
                end
            end

            S_START: begin
                if (baud_tc) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                    uart_tx_d  = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (baud_tc) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
                        uart_tx_d = parity_q;
`else
                        state_d   = S_STOP;
                        uart_tx_d = 1'b1;
`endif
                    end else begin
                        // next bit is the one about to land in shift_q[0]
                        uart_tx_d = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tc) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                    uart_tx_d  = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (baud_tc) begin
                    baud_cnt_d  = '0;
                    state_d     = S_IDLE;
                    uart_tx_d   = 1'b1;
                    tx_status_d = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = S_IDLE;
                baud_cnt_d  = '0;
                bit_cnt_d   = 3'd0;
                uart_tx_d   = 1'b1;
                tx_status_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            uart_tx_q   <= 1'b1;
            tx_status_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            uart_tx_q   <= uart_tx_d;
            tx_status_q <= tx_status_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign uart_tx   = uart_tx_q;
    assign tx_status = tx_status_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Scoreboard bench for uart_tx_serializer with BAUD_DIV = 4. A transaction
// model at the posedge decides which requests are accepted and pushes the
// expected frame (bit list plus accept cycle) into a queue; a line monitor at
// the negedge detects each start bit, pops the expectation and compares every
// bit period, the start latency, back-to-back spacing and tx_status.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       tx_en   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_status;
    logic       uart_tx;

    uart_tx_serializer #(.BAUD_DIV(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] bits;
        longint      acc;
        bit          b2b;
    } exp_t;

    exp_t   sb_q[$];
    int     n_pass = 0;
    int     n_chk  = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame as seen on the wire, LSB first: start 0, data, [parity], stop 1.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (NB == 11) b[9] = ^d;
        return b;
    endfunction

    // ---------------- transaction model ----------------
    int     busy        = 0;
    bit     model_ready = 1'b1;
    bit     have_prev   = 1'b0;
    longint frame_end   = 0;

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            busy      = 0;
            have_prev = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) frame_end = cyc;
        end else if (tx_en) begin
            e.bits = frame_bits(tx_data);
            e.acc  = cyc;
            e.b2b  = have_prev && (cyc == frame_end + 1);
            sb_q.push_back(e);
            busy      = NB * D;
            have_prev = 1'b1;
        end
        model_ready = (busy == 0);
    end

    // ---------------- line monitor ----------------
    bit     mon_on     = 1'b0;
    bit     prev_line  = 1'b1;
    int     mon_cyc    = 0;
    int     mism       = 0;
    int     frame_no   = 0;
    longint last_start = 0;
    exp_t   cur;

    always @(negedge clk) begin
        int bi;
        if (reset) begin
            mon_on    = 1'b0;
            prev_line = 1'b1;
            mism      = 0;
            sb_q.delete();
        end else begin
            chk("tx_status", longint'(tx_status), longint'(model_ready));
            if (!mon_on) begin
                if (uart_tx === 1'b0 && prev_line && sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    chk("start_latency", cyc - cur.acc, 1);
                    if (cur.b2b) chk("b2b_start_gap", cyc - last_start, NB * D + 1);
                    last_start = cyc;
                    mon_on     = 1'b1;
                    mon_cyc    = 0;
                    mism       = 0;
                end else begin
                    chk("idle_line", longint'(uart_tx), 1);
                end
            end
            if (mon_on) begin
                bi = mon_cyc / D;
                if (uart_tx !== cur.bits[bi]) mism++;
                if (mon_cyc % D == D - 1) begin
                    chk($sformatf("frame%0d_bit%0d_bad_cycles", frame_no, bi), mism, 0);
                    mism = 0;
                end
                mon_cyc++;
                if (mon_cyc == NB * D) begin
                    mon_on = 1'b0;
                    frame_no++;
                end
            end
            prev_line = uart_tx;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (tx_status !== 1'b1 && n < NB * D * 3) begin
            @(negedge clk);
            n++;
        end
        if (tx_status !== 1'b1) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready();
        tx_data = d;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    // Called at the negedge of the cycle after the accept cycle.
    task automatic reset_mid_frame(input int k);
        repeat (k) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_async_line", longint'(uart_tx), 1);
        chk("reset_async_status", longint'(tx_status), 1);
        repeat (10) begin
            @(negedge clk);
            chk("reset_hold_line", longint'(uart_tx), 1);
        end
        reset = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) begin
            @(negedge clk);
            chk("reset_line", longint'(uart_tx), 1);
            chk("reset_status", longint'(tx_status), 1);
        end
        reset = 1'b0;

        send(8'h55);
        wait_ready();
        repeat (3) @(negedge clk);

        // busy request with different data must be ignored
        send(8'hA3);
        repeat (10) @(negedge clk);
        tx_en   = 1'b1;
        tx_data = 8'hFF;
        repeat (8) @(negedge clk);
        tx_en   = 1'b0;
        tx_data = 8'h00;
        wait_ready();
        repeat (3) @(negedge clk);

        // continuous request: back-to-back frames
        tx_data = 8'h00;
        tx_en   = 1'b1;
        repeat (3 * (NB * D + 1) + 2) @(negedge clk);
        tx_en   = 1'b0;
        wait_ready();
        repeat (2) @(negedge clk);

        // reset during data bit 3, then a clean frame
        send(8'h0F);
        reset_mid_frame(16);
        send(8'h81);
        wait_ready();
        repeat (2) @(negedge clk);

        // reset during the start bit (line low)
        send(8'hC6);
        reset_mid_frame(0);
        send(8'h3C);
        wait_ready();

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_ready();
        send(8'h03);
        wait_ready();
`endif

        // random traffic, requests and data changing freely
        repeat (3000) begin
            @(negedge clk);
            tx_en   = ($urandom_range(0, 3) == 0);
            tx_data = 8'($urandom);
        end
        tx_en = 1'b0;

        n = 0;
        while ((sb_q.size() > 0 || mon_on) && n < NB * D * 3) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", longint'(sb_q.size()) + longint'(mon_on), 0);
        chk("enough_frames", longint'(frame_no >= 20), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
